// File: rtl/transmission_estimator.sv
// Dark-channel transmission estimator: latches A / 1/A per frame, streams 3x3 windows through a 4-stage pipe.
// Optional TE_T0_CLAMP_EN: clamp out_t from below at T0.
module transmission_estimator #(
   parameter int unsigned PIX_PER_FRAME = 307200,
   parameter int unsigned OMEGA         = 243,
   parameter int unsigned T0            = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [7:0]  a_r,
   input  logic [7:0]  a_g,
   input  logic [7:0]  a_b,
   input  logic [15:0] inv_a_r,
   input  logic [15:0] inv_a_g,
   input  logic [15:0] inv_a_b,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] pix_1,
   input  logic [23:0] pix_2,
   input  logic [23:0] pix_3,
   input  logic [23:0] pix_4,
   input  logic [23:0] pix_5,
   input  logic [23:0] pix_6,
   input  logic [23:0] pix_7,
   input  logic [23:0] pix_8,
   input  logic [23:0] pix_9,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_t,
   output logic [23:0] out_pix,
   output logic [7:0]  out_a_r,
   output logic [7:0]  out_a_g,
   output logic [7:0]  out_a_b,
   output logic        frame_done
);

   localparam int unsigned CW = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(PIX_PER_FRAME - 1);

   if (PIX_PER_FRAME < 1) begin : g_chk_ppf
      $error("PIX_PER_FRAME must be at least 1");
   end
   if (OMEGA > 255 || T0 > 255) begin : g_chk_q08
      $error("OMEGA and T0 are Q0.8 and must fit in 8 bits");
   end

   typedef enum logic [1:0] {WAIT_A, RUN, DRAIN} state_t;
   state_t state, state_nx;

   logic [CW-1:0] pix_cnt;
   logic [7:0]    act_a_r, act_a_g, act_a_b, sh_a_r, sh_a_g, sh_a_b;
   logic [15:0]   act_inv_r, act_inv_g, act_inv_b, sh_inv_r, sh_inv_g, sh_inv_b;
   logic          pend, load_a;
   logic          v1, v2, v3, v4, stall, accept;

   logic [7:0]  s1_mn_r, s1_mn_g, s1_mn_b, s2_m_r, s2_m_g, s2_m_b, s3_d, s4_t;
   logic [23:0] s1_pix, s2_pix, s3_pix, s4_pix;

   logic [8:0][23:0] win;
   logic [7:0]       mn_r, mn_g, mn_b, m_r, m_g, m_b, d, t_fin;

   // (min9 * invA) >> 8, saturated to 8 bits
   function automatic logic [7:0] sat_scale(input logic [7:0] mn, input logic [15:0] inv);
      logic [23:0] p;
      logic [15:0] q;
      p = 24'(mn) * 24'(inv);
      q = 16'(p >> 8);
      return (|q[15:8]) ? 8'hFF : q[7:0];
   endfunction

   assign stall    = v4 & ~out_ready;
   assign accept   = in_valid & in_ready;
   assign win      = {pix_9, pix_8, pix_7, pix_6, pix_5, pix_4, pix_3, pix_2, pix_1};

   assign out_valid = v4;
   assign out_t     = s4_t;
   assign out_pix   = s4_pix;
   assign out_a_r   = act_a_r;
   assign out_a_g   = act_a_g;
   assign out_a_b   = act_a_b;

   always_comb begin
      state_nx   = state;
      in_ready   = 1'b0;
      frame_done = 1'b0;
      load_a     = 1'b0;
      case (state)
         WAIT_A: begin
            if (a_valid || pend) begin
               load_a   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            in_ready = ~stall;
            if (in_valid && !stall && pix_cnt == LAST_IDX) state_nx = DRAIN;
         end
         DRAIN: begin
            if (!v1 && !v2 && !v3 && v4 && out_ready) begin
               frame_done = 1'b1;
               state_nx   = WAIT_A;
            end
         end
         default: state_nx = WAIT_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= WAIT_A;
         pix_cnt <= '0;
      end else begin
         state <= state_nx;
         if (accept) pix_cnt <= (pix_cnt == LAST_IDX) ? '0 : pix_cnt + 1'b1;
      end
   end

   // A direct load in WAIT_A takes priority over the shadow copy and never sets pending
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_a_r <= '0; act_a_g <= '0; act_a_b <= '0;
         act_inv_r <= '0; act_inv_g <= '0; act_inv_b <= '0;
         sh_a_r <= '0; sh_a_g <= '0; sh_a_b <= '0;
         sh_inv_r <= '0; sh_inv_g <= '0; sh_inv_b <= '0;
         pend <= 1'b0;
      end else if (load_a) begin
         if (a_valid) begin
            act_a_r <= a_r; act_a_g <= a_g; act_a_b <= a_b;
            act_inv_r <= inv_a_r; act_inv_g <= inv_a_g; act_inv_b <= inv_a_b;
         end else begin
            act_a_r <= sh_a_r; act_a_g <= sh_a_g; act_a_b <= sh_a_b;
            act_inv_r <= sh_inv_r; act_inv_g <= sh_inv_g; act_inv_b <= sh_inv_b;
         end
         pend <= 1'b0;
      end else if (a_valid) begin
         sh_a_r <= a_r; sh_a_g <= a_g; sh_a_b <= a_b;
         sh_inv_r <= inv_a_r; sh_inv_g <= inv_a_g; sh_inv_b <= inv_a_b;
         pend <= 1'b1;
      end
   end

   always_comb begin
      mn_r = '1;
      mn_g = '1;
      mn_b = '1;
      for (int unsigned i = 0; i < 9; i++) begin
         if (win[i][23:16] < mn_r) mn_r = win[i][23:16];
         if (win[i][15:8]  < mn_g) mn_g = win[i][15:8];
         if (win[i][7:0]   < mn_b) mn_b = win[i][7:0];
      end
   end

   always_comb begin
      logic [15:0] od;
      logic [7:0]  sc, t_raw;
      m_r = sat_scale(s1_mn_r, act_inv_r);
      m_g = sat_scale(s1_mn_g, act_inv_g);
      m_b = sat_scale(s1_mn_b, act_inv_b);
      d = s2_m_r;
      if (s2_m_g < d) d = s2_m_g;
      if (s2_m_b < d) d = s2_m_b;
      od    = 16'(OMEGA) * 16'(s3_d);
      sc    = 8'(od >> 8);
      t_raw = 8'd255 - sc;
`ifdef TE_T0_CLAMP_EN
      t_fin = (t_raw < 8'(T0)) ? 8'(T0) : t_raw;
`else
      t_fin = t_raw;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
         s1_mn_r <= '0; s1_mn_g <= '0; s1_mn_b <= '0; s1_pix <= '0;
         s2_m_r <= '0; s2_m_g <= '0; s2_m_b <= '0; s2_pix <= '0;
         s3_d <= '0; s3_pix <= '0;
         s4_t <= '0; s4_pix <= '0;
      end else if (!stall) begin
         v1 <= accept;
         s1_mn_r <= mn_r; s1_mn_g <= mn_g; s1_mn_b <= mn_b; s1_pix <= pix_5;
         v2 <= v1;
         s2_m_r <= m_r; s2_m_g <= m_g; s2_m_b <= m_b; s2_pix <= s1_pix;
         v3 <= v2;
         s3_d <= d; s3_pix <= s2_pix;
         v4 <= v3;
         s4_t <= t_fin; s4_pix <= s3_pix;
      end
   end

endmodule
